// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for the Tomasulo functional units.
//
// Each cycle one eligible requester (Mem=0, Add=1, Mul=2, spare=3) wins the
// CDB. Its label and data are registered onto BClabel/BCdata with BCEN high,
// and the winner receives a one-cycle BreqAC pulse. When nobody is eligible
// the bus reads zero.
//
// Configuration macro: CDB_ROUND_ROBIN_EN
//   defined   -> round-robin winner selection starting at rr_ptr
//   undefined -> fixed priority, lowest index (Mem) wins
//
// Ports:
//   clk        rising-edge clock
//   nRST       synchronous active-low reset
//   Breq       per-unit broadcast request (level)
//   req_label  flat labels, slot i at [i*LW +: LW]; label 0 is illegal
//   req_data   flat data,   slot i at [i*DW +: DW]
//   BreqAC     registered one-hot grant, one cycle per grant
//   BCEN       registered CDB valid
//   BClabel    registered broadcast tag
//   BCdata     registered broadcast value
//   bad_label  sticky flag: a request was seen with label 0

module cdb_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int LW   = 5
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      Breq,
  input  logic [NREQ*LW-1:0]   req_label,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      BreqAC,
  output logic                 BCEN,
  output logic [LW-1:0]        BClabel,
  output logic [DW-1:0]        BCdata,
  output logic                 bad_label
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BCAST} state_t;

  state_t            state, next_state;
  logic [NREQ-1:0]   elig;
  logic              any_elig;
  logic              any_bad;
  logic [PW-1:0]     win;
  logic [NREQ-1:0]   next_ac;
  logic [LW-1:0]     next_label;
  logic [DW-1:0]     next_data;

  // A unit acked last cycle still holds Breq while it sees the ack, so it is
  // masked out to avoid granting the same result twice.
  always_comb begin
    elig    = '0;
    any_bad = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = Breq[i] && (req_label[i*LW +: LW] != '0) && !BreqAC[i];
      if (Breq[i] && (req_label[i*LW +: LW] == '0))
        any_bad = 1'b1;
    end
  end

  assign any_elig = |elig;

`ifdef CDB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;

  // Scan from the farthest slot back towards rr_ptr so the last hit is the
  // first eligible index at or after rr_ptr (with wrap).
  always_comb begin
    win = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NREQ])
        win = PW'((int'(rr_ptr) + k) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST)
      rr_ptr <= '0;
    else if (any_elig)
      rr_ptr <= (int'(win) == NREQ-1) ? '0 : PW'(win + 1'b1);
  end
`else
  // Fixed priority: descending scan leaves the lowest eligible index.
  always_comb begin
    win = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (elig[k])
        win = PW'(k);
    end
  end
`endif

  // State register, plus the registered bus outputs that follow it.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      BreqAC    <= '0;
      BClabel   <= '0;
      BCdata    <= '0;
      bad_label <= 1'b0;
    end else begin
      state     <= next_state;
      BreqAC    <= next_ac;
      BClabel   <= next_label;
      BCdata    <= next_data;
      bad_label <= bad_label | any_bad;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = any_elig ? BCAST : IDLE;
      BCAST:   next_state = any_elig ? BCAST : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next bus contents; everything is zero when no one is eligible.
  always_comb begin
    next_ac    = '0;
    next_label = '0;
    next_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (any_elig && (win == PW'(i))) begin
        next_ac[i] = 1'b1;
        next_label = req_label[i*LW +: LW];
        next_data  = req_data[i*DW +: DW];
      end
    end
  end

  assign BCEN = (state == BCAST);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven scoreboard bench for cdb_arbiter.
// Each vector drives nRST/Breq/labels/data for one cycle and states the
// expected grant and bad_label; bus label/data expectations follow from the
// vector's own inputs at the expected winner.

module tb_cdb_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LW   = 5;

  logic                 clk = 1'b0;
  logic                 nRST;
  logic [NREQ-1:0]      Breq;
  logic [NREQ*LW-1:0]   req_label;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      BreqAC;
  logic                 BCEN;
  logic [LW-1:0]        BClabel;
  logic [DW-1:0]        BCdata;
  logic                 bad_label;

  cdb_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .Breq      (Breq),
    .req_label (req_label),
    .req_data  (req_data),
    .BreqAC    (BreqAC),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .bad_label (bad_label)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                      rst_n;
    logic [NREQ-1:0]           breq;
    logic [NREQ-1:0][LW-1:0]   lab;
    logic [NREQ-1:0][DW-1:0]   dat;
    logic [NREQ-1:0]           ac;
    logic                      bad;
  } vec_t;

  typedef struct {
    int              idx;
    logic [NREQ-1:0] ac;
    logic            en;
    logic [LW-1:0]   label;
    logic [DW-1:0]   data;
    logic            bad;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [DW-1:0] dflt(input int i, input logic [LW-1:0] l);
    return {4'hA, 4'(i), 19'b0, l};
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic [3:0] breq,
                              input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                              input logic [LW-1:0] l2, input logic [LW-1:0] l3,
                              input logic [3:0] ac, input logic bad);
    vec_t v;
    v.rst_n  = rst_n;
    v.breq   = breq;
    v.lab[0] = l0;
    v.lab[1] = l1;
    v.lab[2] = l2;
    v.lab[3] = l3;
    for (int i = 0; i < NREQ; i++) v.dat[i] = dflt(i, v.lab[i]);
    v.ac  = ac;
    v.bad = bad;
    return v;
  endfunction

  task automatic cmp(input int idx, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    nRST      = v.rst_n;
    Breq      = v.breq;
    req_label = v.lab;
    req_data  = v.dat;
    e.idx   = idx;
    e.ac    = v.ac;
    e.en    = |v.ac;
    e.label = '0;
    e.data  = '0;
    e.bad   = v.bad;
    for (int i = 0; i < NREQ; i++) begin
      if (v.ac[i]) begin
        e.label = v.lab[i];
        e.data  = v.dat[i];
      end
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    cmp(e.idx, "BreqAC",    64'(BreqAC),    64'(e.ac));
    cmp(e.idx, "BCEN",      64'(BCEN),      64'(e.en));
    cmp(e.idx, "BClabel",   64'(BClabel),   64'(e.label));
    cmp(e.idx, "BCdata",    64'(BCdata),    64'(e.data));
    cmp(e.idx, "bad_label", 64'(bad_label), 64'(e.bad));
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    vec_t rst;

    nRST      = 1'b0;
    Breq      = '0;
    req_label = '0;
    req_data  = '0;

    idle = mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
    rst  = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);

    // Reset for two edges, then ten idle cycles.
    vecs.push_back(rst);
    vecs.push_back(rst);
    for (int i = 0; i < 10; i++) vecs.push_back(idle);

    // Single request from Add; held a second cycle, which the ack mask hides.
    v = mk(1, 4'b0010, 0, 5'h09, 0, 0, 4'b0010, 0);
    v.dat[1] = 32'hDEAD_BEEF;
    vecs.push_back(v);
    v.ac = 4'b0000;
    vecs.push_back(v);
    vecs.push_back(idle);

    // Contention from reset: 0, 1, 2 in order, then an unmasked 1-vs-3 race.
    vecs.push_back(rst);
    vecs.push_back(mk(1, 4'b0111, 5'h01, 5'h02, 5'h03, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0110, 5'h01, 5'h02, 5'h03, 0, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b0100, 0,     5'h02, 5'h03, 0, 4'b0100, 0));
`ifdef CDB_ROUND_ROBIN_EN
    vecs.push_back(mk(1, 4'b1010, 0, 5'h0A, 5'h03, 5'h0B, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0010, 0, 5'h0A, 0,     5'h0B, 4'b0010, 0));
`else
    vecs.push_back(mk(1, 4'b1010, 0, 5'h0A, 5'h03, 5'h0B, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 5'h0A, 0,     5'h0B, 4'b1000, 0));
`endif
    vecs.push_back(idle);

    // Units 3 and 0 alternate through the ack mask.
    vecs.push_back(mk(1, 4'b1000, 0,     0, 0, 5'h07, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b1001, 5'h04, 0, 0, 5'h08, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b1001, 5'h05, 0, 0, 5'h08, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b1001, 5'h05, 0, 0, 5'h09, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b1001, 5'h06, 0, 0, 5'h09, 4'b1000, 0));
    vecs.push_back(idle);

    // Units 0 and 2 continuously with fresh labels, then 0-vs-3 race.
    vecs.push_back(rst);
    vecs.push_back(mk(1, 4'b0101, 5'h01, 0, 5'h11, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0101, 5'h02, 0, 5'h11, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b0101, 5'h02, 0, 5'h12, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0101, 5'h03, 0, 5'h12, 0, 4'b0100, 0));
    vecs.push_back(idle);
    vecs.push_back(mk(1, 4'b0110, 0, 5'h0D, 5'h0E, 0, 4'b0010, 0));
`ifdef CDB_ROUND_ROBIN_EN
    vecs.push_back(mk(1, 4'b1001, 5'h01, 0, 0, 5'h0F, 4'b1000, 0));
`else
    vecs.push_back(mk(1, 4'b1001, 5'h01, 0, 0, 5'h0F, 4'b0001, 0));
`endif
    vecs.push_back(idle);

    // Label 0 from Mul is never granted and latches bad_label; then a reset
    // lands mid-broadcast and the held request is granted again afterwards.
    vecs.push_back(mk(1, 4'b0100, 0,     0,     0, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0110, 0,     5'h0C, 0, 0, 4'b0010, 1));
    vecs.push_back(mk(1, 4'b0100, 0,     5'h0C, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0001, 5'h1F, 0,     0, 0, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 5'h1F, 0,     0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0001, 5'h1F, 0,     0, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0001, 5'h1F, 0,     0, 0, 4'b0000, 0));
    vecs.push_back(idle);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
      checkOutput();
    end

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
